// File: rtl/board_pixel_streamer.sv
// Snapshots the game board colour image and streams it one cell per transfer
// over a valid/ready interface, row-major, with frame/line markers.
module board_pixel_streamer #(
  parameter int ROWS           = 12,
  parameter int COLS           = 10,
  parameter int BPP            = 8,
  parameter int REFRESH_CYCLES = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:COLS*BPP-1]   colorValues [0:ROWS-1],
  input  logic                  frame_req,
  input  logic                  pix_ready,
  output logic                  pix_valid,
  output logic [BPP-1:0]        pix_data,
  output logic [3:0]            pix_row,
  output logic [3:0]            pix_col,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            dbg_state
);

  // Handshake: a pixel moves on a clk edge where pix_valid && pix_ready; while
  // pix_valid is high and pix_ready low, every pix_* output holds its value.

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);
  localparam int TW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int RC_LAST_I = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TIMER_LAST = TW'(RC_LAST_I);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_STREAM  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          row_q, row_d;
  logic [3:0]          col_q, col_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pending_q, pending_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [0:COLS*BPP-1] snap_q [0:ROWS-1];
  logic [0:COLS*BPP-1] snap_d [0:ROWS-1];

  logic tick;
  logic start_evt;
  logic xfer;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    snap_d    = snap_q;

    tick      = (REFRESH_CYCLES != 0) && (timer_q == TIMER_LAST);
    start_evt = frame_req | tick;
    xfer      = valid_q & pix_ready;

    if (REFRESH_CYCLES == 0 || tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_evt || pending_q) begin
          state_d   = S_CAPTURE;
          pending_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_CAPTURE: begin
        snap_d  = colorValues;
        row_d   = '0;
        col_d   = '0;
        valid_d = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (xfer) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Requests arriving while a frame is in flight collapse into one queued start.
    if (state_q != S_IDLE && start_evt) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      snap_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      snap_q    <= snap_d;
    end
  end

  // Counters only move on transfers, so these decodes are stable across stalls.
  assign pix_valid  = valid_q;
  assign pix_data   = valid_q ? snap_q[row_q][int'(col_q)*BPP +: BPP] : '0;
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign pix_sof    = valid_q && (row_q == 4'd0) && (col_q == 4'd0);
  assign pix_eol    = valid_q && (col_q == LAST_COL);
  assign pix_eof    = valid_q && (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_board_pixel_streamer.sv
// Randomized bench for board_pixel_streamer: a frame-level reference model
// predicts every pixel from the image present at capture time.
module tb_board_pixel_streamer;

  localparam int ROWS = 12;
  localparam int COLS = 10;
  localparam int BPP  = 8;
  localparam int PW   = 19;
  localparam int AUTO_CYCLES = 2150;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_a_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:COLS*BPP-1] color_values [0:ROWS-1];
  logic       frame_req = 1'b0;
  logic       pix_ready = 1'b1;
  logic       pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done;
  logic [7:0] pix_data;
  logic [3:0] pix_row, pix_col;
  logic [1:0] dbg_state;

  logic       a_valid, a_sof, a_eol, a_eof, a_busy, a_done;
  logic [7:0] a_data;
  logic [3:0] a_row, a_col;
  logic [1:0] a_dbg;
  logic       a_req = 1'b0;
  logic       a_ready = 1'b1;

  board_pixel_streamer #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .colorValues(color_values), .frame_req(frame_req),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data), .pix_row(pix_row),
    .pix_col(pix_col), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  board_pixel_streamer #(.ROWS(ROWS), .COLS(COLS), .BPP(BPP), .REFRESH_CYCLES(200)) dut_auto (
    .clk(clk), .rst_n(rst_a_n), .colorValues(color_values), .frame_req(a_req),
    .pix_ready(a_ready), .pix_valid(a_valid), .pix_data(a_data), .pix_row(a_row),
    .pix_col(a_col), .pix_sof(a_sof), .pix_eol(a_eol), .pix_eof(a_eof),
    .busy(a_busy), .frame_done(a_done), .dbg_state(a_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus controls
  bit ready_mode = 1'b0;
  bit scramble   = 1'b0;

  task automatic rand_image();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        color_values[r][c*BPP +: BPP] = 8'($urandom);
  endtask

  task automatic load_pattern();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        color_values[r][c*BPP +: BPP] = {4'(r), 4'(c)};
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      pix_ready = ready_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (scramble) rand_image();
    end
  end

  // scoreboard: one expected entry per pixel of the captured image
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] cur_pix, prev_out, exp_pix;
  bit stall_prev = 1'b0;
  bit prev_eof_xfer = 1'b0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int sof_cnt = 0;
  int eol_cnt = 0;

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        exp_q.push_back({4'(r), 4'(c), color_values[r][c*BPP +: BPP],
                         (r == 0 && c == 0), (c == COLS - 1),
                         (r == ROWS - 1 && c == COLS - 1)});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev    = 1'b0;
      prev_eof_xfer = 1'b0;
    end else begin
      cur_pix = {pix_row, pix_col, pix_data, pix_sof, pix_eol, pix_eof};
      if (stall_prev) check("stall_hold", {pix_valid, cur_pix}, {1'b1, prev_out});
      if (frame_done) begin
        done_cnt++;
        check("done_after_eof", prev_eof_xfer, 1);
        check("busy_low_at_done", busy, 0);
      end
      if (busy && !pix_valid) begin
        check("capture_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        push_frame();
        xfer_cnt = 0;
        sof_cnt  = 0;
        eol_cnt  = 0;
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", cur_pix, '0);
        end else begin
          exp_pix = exp_q.pop_front();
          check("pixel", cur_pix, exp_pix);
        end
        check("busy_in_stream", busy, 1);
        xfer_cnt++;
        if (pix_sof) sof_cnt++;
        if (pix_eol) eol_cnt++;
      end
      prev_eof_xfer = pix_valid && pix_ready && pix_eof;
      stall_prev    = pix_valid && !pix_ready;
      prev_out      = cur_pix;
    end
  end

  task automatic wait_done(input int max_cycles);
    int start;
    bit seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      if (done_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_done_seen", seen, 1);
  endtask

  task automatic wait_xfers(input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (xfer_cnt >= n) begin
        seen = 1'b1;
        break;
      end
    end
    check("xfer_reached", seen, 1);
  endtask

  task automatic check_frame_end(input string tag);
    check({tag, "_count"}, xfer_cnt, ROWS * COLS);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  int auto_exp[$];
  int auto_seen;
  int done_before;
  bit saw_busy;

  initial begin
    rand_image();
    #2;
    check("reset_outputs", {pix_valid, pix_data, pix_row, pix_col, pix_sof, pix_eol, pix_eof, busy, frame_done}, '0);
    check("reset_outputs_auto", {a_valid, a_data, a_row, a_col, a_sof, a_eol, a_eof, a_busy, a_done}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    rst_a_n = 1'b1;

    // Auto refresh: expiry on edge 200k, frame_done visible 121 edges later.
    for (int k = 1; 200 * k + 121 <= AUTO_CYCLES; k++) auto_exp.push_back(200 * k + 121);
    auto_seen = 0;
    for (int i = 1; i <= AUTO_CYCLES; i++) begin
      @(negedge clk);
      if (a_done) begin
        auto_seen++;
        if (auto_exp.size() == 0) check("auto_extra_done", i, 0);
        else check("auto_done_edge", i, auto_exp.pop_front());
      end
    end
    check("auto_done_count", auto_seen, 10);

    // Single frame, ready high, {row,col} pattern
    ready_mode = 1'b0;
    load_pattern();
    @(posedge clk); #1 frame_req = 1'b1;
    @(posedge clk); #1 frame_req = 1'b0;
    @(negedge clk);
    check("capture_valid_low", pix_valid, 0);
    check("capture_busy_high", busy, 1);
    @(negedge clk);
    check("first_valid", pix_valid, 1);
    check("first_pixel", {pix_row, pix_col, pix_data, pix_sof}, {4'd0, 4'd0, 8'h00, 1'b1});
    wait_done(400);
    check_frame_end("single");
    check("single_sof_count", sof_cnt, 1);
    check("single_eol_count", eol_cnt, ROWS);
    @(negedge clk);
    check("idle_after_done", {pix_valid, busy, frame_done}, 3'b000);

    // Backpressure at ~30% ready
    rand_image();
    ready_mode = 1'b1;
    pulse_req();
    wait_done(3000);
    check_frame_end("backpressure");

    // Snapshot integrity: image churns every cycle
    rand_image();
    scramble = 1'b1;
    pulse_req();
    wait_done(3000);
    check_frame_end("snapshot");
    scramble   = 1'b0;
    ready_mode = 1'b0;

    // Queued request: two pulses mid-frame give exactly one extra frame
    rand_image();
    pulse_req();
    wait_xfers(50);
    pulse_req();
    wait_xfers(60);
    pulse_req();
    wait_done(400);
    check_frame_end("queued_first");
    @(negedge clk);
    check("queued_idle_gap", {busy, pix_valid}, 2'b00);
    @(negedge clk);
    check("queued_capture", {busy, pix_valid}, 2'b10);
    wait_done(400);
    check_frame_end("queued_second");
    done_before = done_cnt;
    saw_busy = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("no_third_frame", saw_busy, 0);
    check("no_extra_done", done_cnt, done_before);

    // Reset mid-stream at pixel 37
    rand_image();
    pulse_req();
    wait_xfers(37);
    done_before = done_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {pix_valid, pix_data, pix_row, pix_col, pix_sof, pix_eol, pix_eof, busy, frame_done}, '0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt, done_before);
    check("idle_after_abort", {busy, pix_valid}, 2'b00);
    load_pattern();
    pulse_req();
    wait_done(400);
    check_frame_end("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
